// File: rtl/nonconsec_pkg.sv
// rtl/nonconsec_pkg.sv - shared state type, LFSR taps and width defaults for nonconsec_pulse_gen
package nonconsec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam int         CNT_W_DEF     = 4;
  localparam int         GAP_W_DEF     = 4;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nonconsec_pulse_gen_lfsr8.sv
// rtl/nonconsec_pulse_gen_lfsr8.sv - 8-bit maximal-length LFSR used for gap jitter
module lfsr8
  import nonconsec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  // Free-running shift register; seed must be nonzero to stay out of the lock-up state
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/nonconsec_pulse_gen.sv
// rtl/nonconsec_pulse_gen.sv - emits N non-consecutive b pulses per rising edge of a (optional JITTER_EN)
module nonconsec_pulse_gen
  import nonconsec_pkg::*;
#(
  parameter int         CNT_W     = CNT_W_DEF,
  parameter int         GAP_W     = GAP_W_DEF,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic [CNT_W-1:0] cnt_cfg,
  input  logic [GAP_W-1:0] gap_cfg,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             ovr
);

  // Two extra bits so that G plus up to 3 cycles of jitter never wraps
  localparam int GCW = GAP_W + 2;

  state_t           state, state_nxt;
  logic             a_q;
  logic             rise;
  logic [CNT_W-1:0] pulse_cnt, pulse_nxt;
  logic [GAP_W-1:0] g_lat, g_nxt;
  logic [GCW-1:0]   gap_cnt, gap_nxt, gap_load;
  logic [1:0]       jitter;

`ifdef JITTER_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign jitter      = lfsr_q[1:0];
  assign unused_lfsr = ^lfsr_q[7:2];
`else
  logic unused_seed;

  assign jitter      = 2'b00;
  assign unused_seed = ^LFSR_SEED;
`endif

  assign rise     = a & ~a_q;
  assign gap_load = GCW'(g_lat) + GCW'(jitter);

  // Next-state and counter updates; rises outside IDLE leave the burst untouched
  always_comb begin
    state_nxt = state;
    pulse_nxt = pulse_cnt;
    gap_nxt   = gap_cnt;
    g_nxt     = g_lat;
    case (state)
      IDLE: begin
        if (rise) begin
          g_nxt     = gap_cfg;
          pulse_nxt = cnt_cfg;
          state_nxt = (cnt_cfg != '0) ? PULSE : DONE;
        end
      end
      PULSE: begin
        pulse_nxt = pulse_cnt - CNT_W'(1);
        if (pulse_cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = GAP;
          gap_nxt   = gap_load;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = PULSE;
        end else begin
          gap_nxt = gap_cnt - GCW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and outputs registered together so outputs follow the new state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= 1'b0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
      g_lat     <= '0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_nxt;
      a_q       <= a;
      pulse_cnt <= pulse_nxt;
      gap_cnt   <= gap_nxt;
      g_lat     <= g_nxt;
      b         <= (state_nxt == PULSE);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      ovr       <= rise & (state != IDLE);
    end
  end

endmodule

// File: tb/tb_nonconsec_pulse_gen.sv
// tb/tb_nonconsec_pulse_gen.sv - scoreboard bench for nonconsec_pulse_gen (JITTER_EN aware)
module tb_nonconsec_pulse_gen;

  localparam logic [7:0] SEED = 8'hA5;

  typedef struct {
    logic b;
    logic busy;
    logic done;
    logic ovr;
    int   off;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic [3:0] cnt_cfg;
  logic [3:0] gap_cfg;
  logic       b, busy, done, ovr;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  string      cur = "init";
  logic [7:0] m_lfsr = 8'h00;

  nonconsec_pulse_gen dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .cnt_cfg (cnt_cfg),
    .gap_cfg (gap_cfg),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] step8(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic exp_t mk(input logic eb, input logic ebusy, input logic edone);
    exp_t e;
    e.b    = eb;
    e.busy = ebusy;
    e.done = edone;
    e.ovr  = 1'b0;
    e.off  = 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One clock; afterwards compare the cycle that just began against the scoreboard head
  task automatic tick();
    exp_t e;
    @(posedge clk);
    m_lfsr = rst ? SEED : step8(m_lfsr);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s@k+%0d.b", cur, e.off), {31'd0, b}, {31'd0, e.b});
      check($sformatf("%s@k+%0d.busy", cur, e.off), {31'd0, busy}, {31'd0, e.busy});
      check($sformatf("%s@k+%0d.done", cur, e.off), {31'd0, done}, {31'd0, e.done});
      check($sformatf("%s@k+%0d.ovr", cur, e.off), {31'd0, ovr}, {31'd0, e.ovr});
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

  // Called just before the rising-edge posedge k; entry i describes cycle k+1+i
  task automatic expect_burst(input int n, input int g, input int ovr_off,
                              input int max_len, input int trail);
    exp_t       seq[$];
    exp_t       e;
    int         gl;
    logic [7:0] lv;
    lv = m_lfsr;
    if (n > 0) begin
      for (int i = 0; i < n; i++) begin
        lv = step8(lv);
        seq.push_back(mk(1'b1, 1'b1, 1'b0));
        if (i < n - 1) begin
          gl = g + 1;
`ifdef JITTER_EN
          gl += int'(lv[1:0]);
`endif
          for (int j = 0; j < gl; j++) begin
            lv = step8(lv);
            seq.push_back(mk(1'b0, 1'b1, 1'b0));
          end
        end
      end
    end
    seq.push_back(mk(1'b0, 1'b1, 1'b1));
    for (int i = 0; i < trail; i++) seq.push_back(mk(1'b0, 1'b0, 1'b0));
    if (ovr_off > 0 && ovr_off <= seq.size()) seq[ovr_off-1].ovr = 1'b1;
    for (int i = 0; i < seq.size(); i++) begin
      if (max_len > 0 && i >= max_len) break;
      e = seq[i];
      e.off = i + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_std(input string name, input int n, input int g, input int trail);
    cur     = name;
    cnt_cfg = 4'(n);
    gap_cfg = 4'(g);
    a       = 1'b1;
    expect_burst(n, g, 0, 0, trail);
    tick();
    a = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z     = mk(1'b0, 1'b0, 1'b0);
    rst     = 1'b1;
    a       = 1'b0;
    cnt_cfg = 4'd0;
    gap_cfg = 4'd0;
    tick();
    tick();
    cur = "reset";
    check("reset.b", {31'd0, b}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.ovr", {31'd0, ovr}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    run_std("n2g0", 2, 0, 4);
    run_std("n3g2", 3, 2, 20);
    run_std("n0", 0, 5, 4);
    run_std("n5g0", 5, 0, 4);
    run_std("n15g15", 15, 15, 4);

    // Second rise during GAP: flagged, burst unaffected
    cur     = "ovr_gap";
    cnt_cfg = 4'd4;
    gap_cfg = 4'd1;
    a       = 1'b1;
    expect_burst(4, 1, 4, 0, 4);
    tick();
    a = 1'b0;
    tick();
    tick();
    a = 1'b1;
    tick();
    a = 1'b0;
    drain();

    // Rise during DONE is ignored and flagged; next cycle is IDLE again
    cur     = "ovr_done";
    cnt_cfg = 4'd1;
    gap_cfg = 4'd0;
    a       = 1'b1;
    expect_burst(1, 0, 3, 0, 4);
    tick();
    a = 1'b0;
    tick();
    a = 1'b1;
    tick();
    a = 1'b0;
    drain();

    // Reset at k+3 of an N=3 burst with a held high through release
    cur     = "rst_abort";
    cnt_cfg = 4'd3;
    gap_cfg = 4'd2;
    a       = 1'b1;
    expect_burst(3, 2, 0, 3, 0);
    tick();
    tick();
    tick();
    rst   = 1'b1;
    z.off = 4;
    exp_q.push_back(z);
    tick();
    rst = 1'b0;
    cur = "rst_rearm";
    expect_burst(3, 2, 0, 0, 4);
    tick();
    a = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nonconsec_pulse_gen.md
Name: nonconsec_pulse_gen

Overview:
- Stimulus-side responder for the non-consecutive repetition handshake. On a rising edge of trigger `a`, it emits exactly N single-cycle pulses on `b`, with at least one low cycle between pulses, then holds `b` low.
- It is the synthesizable producer that the `$rose(a) |-> strong(b[=N])` checkers expect.
- It sits between a test sequencer and the DUT or checker, driving `b` as a registered output.

Parameters:
- CNT_W, 4, width of the pulse-count config; up to 15 pulses per trigger.
- GAP_W, 4, width of the gap config.
- LFSR_SEED, 8'hA5, nonzero reset seed for the jitter LFSR (used only with JITTER_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a  in  1  trigger level; its rising edge starts a burst.
- cnt_cfg  in  CNT_W  number of b pulses N; sampled on the accepted rising edge.
- gap_cfg  in  GAP_W  low cycles between pulses minus 1; sampled on the accepted rising edge.
- b  out  1  registered pulse output.
- busy  out  1  high from the accepted edge until the done cycle, inclusive.
- done  out  1  single-cycle pulse after the last b pulse.
- ovr  out  1  single-cycle flag: rising edge seen while not IDLE; the edge is ignored.

Behaviour:
- Reset (rst=1 at posedge):
  - b, busy, done, ovr = 0; state = IDLE; a_q = 0; pulse and gap counters = 0.
  - Reset mid-burst aborts the burst immediately with no further pulses.
- Edge detect: rise = a & ~a_q; a_q is registered every cycle. If `a` is held high across reset release, one rise is seen on the first post-reset cycle, matching $rose semantics.
- States: IDLE, PULSE, GAP, DONE (enum, 2 bits).
- IDLE:
  - rise at posedge k with cnt_cfg != 0: latch N = cnt_cfg and G = gap_cfg; go to PULSE. b=1 and busy=1 are visible after posedge k, so the first pulse occupies cycle k+1.
  - rise with cnt_cfg == 0: go directly to DONE (zero pulses; busy=1 and done=1 for one cycle).
- PULSE: b=1 for exactly one cycle; decrement the remaining count.
  - If remaining becomes 0, go to DONE.
  - Otherwise go to GAP, loading the gap counter with G.
- GAP: b=0. The counter decrements each cycle; at 0, go to PULSE. Low length = G+1 cycles (minimum 1), so pulses are never consecutive.
- DONE: b=0, done=1, busy=1 for one cycle, then IDLE. A rise in DONE is ignored with ovr=1. A new burst can start on the first IDLE cycle.
- Overlap: a rise in any non-IDLE state pulses ovr for one cycle (registered, the cycle after detection). The burst in progress is unaffected, and latched N/G do not change.
- Burst timing: total busy cycles = N + (N-1)(G+1) + 1 for N>0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: JITTER_EN.
- Defined:
  - An 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4), reset to LFSR_SEED, advances every cycle.
  - Each gap load uses G + lfsr[1:0], so the low length is G+1..G+4. Pulse count N is unchanged.
  - An lfsr value of 0 is impossible, since the seed must be nonzero.
- Undefined: no LFSR logic; gaps are exactly G+1 cycles.

Decomposition:
- Package nonconsec_pkg:
  - state_t enum {IDLE, PULSE, GAP, DONE}.
  - LFSR_TAPS constant.
  - Default width localparams.
- Sub-module lfsr8 (clk, rst, seed, q[7:0]): instantiated only under JITTER_EN.
- Edge detect, counters and FSM stay in the top module.

Test Plan:
- N=2, G=0; a rises before posedge k → b=1 at cycles k+1 and k+3; done at k+4; busy k+1..k+4; ovr never set. A `$rose(a)|->strong(b[=2])` check passes.
- N=3, G=2 → b high at k+1, k+5, k+9; exactly 3 pulses; done at k+10; b low for 20 following cycles.
- N=0 → no b pulse; done=1 and busy=1 for one cycle at k+1; state returns to IDLE.
- N=4, G=1, second rise of `a` at k+3 → ovr=1 at k+4; still exactly 4 pulses, at k+1, k+4, k+7, k+10.
- rst asserted at k+3 of an N=3 burst → b, busy, done = 0 from k+4 on; no further pulses. `a` held high through release gives one new burst starting after the first post-reset posedge.
- JITTER_EN, N=5, G=0, seed 8'hA5 → 5 pulses; every gap is 1..4 cycles and matches the reference-model LFSR; no consecutive b highs.
